// File: rtl/mult_pkg.sv
// Shared constants, types and helpers for the partial-product array multiplier.
// Signed (Baugh-Wooley) mode is selected by defining UNSIGNED_MULTIPLIER_SIGNED_EN.
package mult_pkg;

  localparam int unsigned DEFAULT_INPUT_WIDTH = 4;
  localparam int unsigned PROD_W = 2 * DEFAULT_INPUT_WIDTH;

  typedef logic [DEFAULT_INPUT_WIDTH-1:0] pp_row_t;
  typedef logic [PROD_W-1:0]              prod_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mult_pp_row.sv
// One array row: ripple-carry adds a partial-product row to the shifted running sum.
module mult_pp_row #(
  parameter int unsigned width = 4
) (
  input  logic [width-1:0] acc,
  input  logic [width-1:0] pp,
  output logic [width-1:0] sum,
  output logic             carry
);

  logic [width:0] chain;

  assign chain[0] = 1'b0;

  for (genvar j = 0; j < width; j++) begin : g_fa
    assign sum[j]     = acc[j] ^ pp[j] ^ chain[j];
    assign chain[j+1] = (acc[j] & pp[j]) | (acc[j] & chain[j]) | (pp[j] & chain[j]);
  end

  assign carry = chain[width];

endmodule

// File: rtl/unsigned_multiplier.sv
// Registered full-precision array multiplier, one cycle latency, one product per cycle.
// Define UNSIGNED_MULTIPLIER_SIGNED_EN for two's complement operands (Baugh-Wooley).
module unsigned_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned input_width = DEFAULT_INPUT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [input_width-1:0]     a,
  input  logic [input_width-1:0]     b,
  output logic [2*input_width-1:0]   y
);

  localparam int unsigned PROD_W = 2 * input_width;

  logic [input_width-1:0] pp [input_width];
  logic [input_width-1:0] row_sum [input_width];
  logic [input_width-1:0] row_carry;
  logic [PROD_W-1:0]      prod;
  logic                   msb_corr;

  always_comb begin
    for (int unsigned i = 0; i < input_width; i++) begin
      for (int unsigned j = 0; j < input_width; j++) begin
        pp[i][j] = a[j] & b[i];
`ifdef UNSIGNED_MULTIPLIER_SIGNED_EN
        // Cross terms involving exactly one sign bit carry negative weight.
        if ((i == input_width - 1) != (j == input_width - 1)) begin
          pp[i][j] = ~pp[i][j];
        end
`endif
      end
    end
  end

  // Baugh-Wooley correction: +2^n enters as the first row's carry, +2^(2n-1) flips the MSB.
`ifdef UNSIGNED_MULTIPLIER_SIGNED_EN
  assign row_carry[0] = 1'b1;
  assign msb_corr     = 1'b1;
`else
  assign row_carry[0] = 1'b0;
  assign msb_corr     = 1'b0;
`endif

  assign row_sum[0] = pp[0];

  for (genvar i = 1; i < input_width; i++) begin : g_row
    mult_pp_row #(
      .width(input_width)
    ) u_row (
      .acc  ({row_carry[i-1], row_sum[i-1][input_width-1:1]}),
      .pp   (pp[i]),
      .sum  (row_sum[i]),
      .carry(row_carry[i])
    );
  end

  always_comb begin
    prod = '0;
    for (int unsigned i = 0; i < input_width; i++) begin
      prod[i] = row_sum[i][0];
    end
    prod[PROD_W-1:input_width] = {row_carry[input_width-1] ^ msb_corr,
                                  row_sum[input_width-1][input_width-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y <= '0;
    end else begin
      y <= prod;
    end
  end

endmodule

// File: tb/tb_unsigned_multiplier.sv
// Directed and exhaustive n=4 checks of the registered multiplier (either build mode).
module tb_unsigned_multiplier;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] y;

  int n_checks;
  int n_fails;

  unsigned_multiplier #(
    .input_width(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .a  (a),
    .b  (b),
    .y  (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 8'h%02h expected 8'h%02h", tag, got, exp);
    end
  endtask

  // Apply inputs on the falling edge, then sample just after the next rising edge.
  task automatic step(input logic r, input logic [3:0] av, input logic [3:0] bv);
    @(negedge clk);
    rst = r;
    a   = av;
    b   = bv;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] golden(input logic [3:0] av, input logic [3:0] bv);
`ifdef UNSIGNED_MULTIPLIER_SIGNED_EN
    int sa;
    int sb;
    int p;
    sa = (av[3]) ? int'(av) - 16 : int'(av);
    sb = (bv[3]) ? int'(bv) - 16 : int'(bv);
    p  = sa * sb;
    return p[7:0];
`else
    int p;
    p = int'(av) * int'(bv);
    return p[7:0];
`endif
  endfunction

  logic [7:0] exp_59, exp_5f, exp_ff, exp_1d, held;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    a   = 4'd5;
    b   = 4'd9;
`ifdef UNSIGNED_MULTIPLIER_SIGNED_EN
    exp_59 = 8'hDD;
    exp_5f = 8'hFB;
    exp_ff = 8'h01;
    exp_1d = 8'hFD;
`else
    exp_59 = 8'h2D;
    exp_5f = 8'h4B;
    exp_ff = 8'hE1;
    exp_1d = 8'h0D;
`endif

    step(1'b1, 4'd5, 4'd9);
    check_eq("reset_edge1", y, 8'h00);
    step(1'b1, 4'd5, 4'd9);
    check_eq("reset_edge2", y, 8'h00);
    step(1'b0, 4'd5, 4'd9);
    check_eq("first_after_reset", y, exp_59);

    step(1'b0, 4'd0, 4'd0);
    check_eq("zero_zero", y, 8'h00);
    step(1'b0, 4'd5, 4'd0);
    check_eq("five_zero", y, 8'h00);
    step(1'b0, 4'd5, 4'd9);
    check_eq("five_nine", y, exp_59);
    step(1'b0, 4'd5, 4'd15);
    check_eq("five_fifteen", y, exp_5f);
    step(1'b0, 4'd15, 4'd15);
    check_eq("max_max", y, exp_ff);
    step(1'b0, 4'd1, 4'd13);
    check_eq("one_times_b", y, exp_1d);

    // Operand changes between edges must not disturb the registered product.
    held = y;
    a = 4'd3;
    b = 4'd7;
    #2;
    check_eq("hold_between_edges", y, exp_1d);
    check_eq("hold_value", y, held);

    for (int k = 0; k < 256; k++) begin
      logic [7:0] kv;
      kv = k[7:0];
      if (k == 100) begin
        step(1'b1, kv[7:4], kv[3:0]);
        check_eq("mid_run_reset", y, 8'h00);
      end else begin
        step(1'b0, kv[7:4], kv[3:0]);
        check_eq("exhaustive", y, golden(kv[7:4], kv[3:0]));
      end
    end

    step(1'b0, 4'd8, 4'd8);
`ifdef UNSIGNED_MULTIPLIER_SIGNED_EN
    check_eq("min_min", y, 8'h40);
`else
    check_eq("min_min", y, 8'h40);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
